// File: rtl/miim_arb_pkg.sv
// Shared definitions for the MIIM round-robin scheduler: FSM states,
// command-word field positions and counter widths.
package miim_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RUN,
      ST_GAP
   } state_t;

   // Requester command word layout
   localparam int CMD_WR_BIT   = 31;
   localparam int CMD_PHY_MSB  = 30;
   localparam int CMD_PHY_LSB  = 26;
   localparam int CMD_REG_MSB  = 25;
   localparam int CMD_REG_LSB  = 21;
   localparam int CMD_DATA_MSB = 15;
   localparam int CMD_DATA_LSB = 0;

   // Transaction timeout counter and inter-transaction gap counter widths
   localparam int TMO_W = 16;
   localparam int GAP_W = 4;

endpackage

// File: rtl/miim_rr_scheduler_if.sv
// Requester-side and eth_miim-side signals of the MIIM scheduler.
// slave = scheduler view, master = requesters plus management engine.
interface miim_rr_scheduler_if #(
   parameter int N_REQ = 3
) ();

   logic [N_REQ-1:0]    req_valid;
   logic [32*N_REQ-1:0] req_cmd;
   logic [N_REQ-1:0]    rsp_done;
   logic                rsp_err;
   logic [15:0]         rsp_rdata;
   logic [N_REQ-1:0]    grant;
   logic                miim_wctrl;
   logic                miim_rstat;
   logic [4:0]          miim_fiad;
   logic [4:0]          miim_rgad;
   logic [15:0]         miim_ctrl;
   logic                miim_busy;
   logic                miim_wstart;
   logic                miim_rstart;
   logic                miim_rupd;
   logic [15:0]         miim_prsd;

   modport slave (
      input  req_valid, req_cmd, miim_busy, miim_wstart, miim_rstart, miim_rupd, miim_prsd,
      output rsp_done, rsp_err, rsp_rdata, grant,
             miim_wctrl, miim_rstat, miim_fiad, miim_rgad, miim_ctrl
   );

   modport master (
      output req_valid, req_cmd, miim_busy, miim_wstart, miim_rstart, miim_rupd, miim_prsd,
      input  rsp_done, rsp_err, rsp_rdata, grant,
             miim_wctrl, miim_rstat, miim_fiad, miim_rgad, miim_ctrl
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// the pointer, wrapping around. Returns one-hot, index and any-valid.
module rr_pick #(
   parameter  int N_REQ = 3,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [IW-1:0] cand;

   // Scan from the pointer position, keep the first hit
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IW'((32'(ptr) + i) % N_REQ);
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/miim_rr_scheduler.sv
// Shares one eth_miim engine among N_REQ requesters, one MDIO command at a
// time, round-robin, with a forced idle gap and a transaction timeout.
module miim_rr_scheduler
   import miim_arb_pkg::*;
#(
   parameter int N_REQ       = 3,
   parameter int GAP_CYC     = 3,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                clk,
   input  logic                reset,
   miim_rr_scheduler_if.slave  bus
);

   localparam int IW = $clog2(N_REQ);

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q;
   logic [N_REQ-1:0]  pick_oh;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic [31:0]       sel_cmd;
   logic              is_wr_q;
   logic              rupd_seen_q;
   logic [TMO_W-1:0]  tmo_q;
   logic [GAP_W-1:0]  gap_q;
   logic              start_ok;
   logic              issue_ack;
   logic              xfer_done;
   logic              tmo_hit;
   logic              gap_last;
   logic              unused_cmd_bits;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .gnt (pick_oh),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Command word of the current round-robin winner
   always_comb begin
      sel_cmd = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pick_idx == IW'(i))
            sel_cmd = bus.req_cmd[32*i +: 32];
      end
   end

   assign unused_cmd_bits = ^sel_cmd[20:16];

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic; in ISSUE a timeout beats a late start strobe so the
   // counter can never run past its terminal value
   always_comb begin
      start_ok  = pick_any & ~bus.miim_busy;
      issue_ack = is_wr_q ? bus.miim_wstart : bus.miim_rstart;
      xfer_done = ~bus.miim_busy & (is_wr_q | rupd_seen_q | bus.miim_rupd);
      tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
      gap_last  = (({1'b0, gap_q} + 5'd1) >= 5'(GAP_CYC));
      state_d   = state_q;
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (tmo_hit)        state_d = ST_GAP;
            else if (issue_ack) state_d = ST_RUN;
         end
         ST_RUN:   if (xfer_done || tmo_hit) state_d = ST_GAP;
         ST_GAP:   if (gap_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Registered outputs, command latches, pointer and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q          <= '0;
         is_wr_q        <= 1'b0;
         rupd_seen_q    <= 1'b0;
         tmo_q          <= '0;
         gap_q          <= '0;
         bus.grant      <= '0;
         bus.rsp_done   <= '0;
         bus.rsp_err    <= 1'b0;
         bus.rsp_rdata  <= '0;
         bus.miim_wctrl <= 1'b0;
         bus.miim_rstat <= 1'b0;
         bus.miim_fiad  <= '0;
         bus.miim_rgad  <= '0;
         bus.miim_ctrl  <= '0;
      end else begin
         bus.rsp_done <= '0;
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  bus.grant      <= pick_oh;
                  ptr_q          <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                  is_wr_q        <= sel_cmd[CMD_WR_BIT];
                  bus.miim_wctrl <= sel_cmd[CMD_WR_BIT];
                  bus.miim_rstat <= ~sel_cmd[CMD_WR_BIT];
                  bus.miim_fiad  <= sel_cmd[CMD_PHY_MSB:CMD_PHY_LSB];
                  bus.miim_rgad  <= sel_cmd[CMD_REG_MSB:CMD_REG_LSB];
                  bus.miim_ctrl  <= sel_cmd[CMD_DATA_MSB:CMD_DATA_LSB];
                  rupd_seen_q    <= 1'b0;
                  tmo_q          <= '0;
               end
            end
            ST_ISSUE, ST_RUN: begin
               tmo_q <= tmo_q + 1'b1;
               if (state_q == ST_RUN && !is_wr_q && bus.miim_rupd && !(tmo_hit && !xfer_done)) begin
                  bus.rsp_rdata <= bus.miim_prsd;
                  rupd_seen_q   <= 1'b1;
               end
               if (state_d == ST_GAP) begin
                  bus.miim_wctrl <= 1'b0;
                  bus.miim_rstat <= 1'b0;
                  bus.rsp_done   <= bus.grant;
                  bus.rsp_err    <= (state_q == ST_ISSUE) | ~xfer_done;
                  bus.grant      <= '0;
                  gap_q          <= '0;
               end else if (state_d == ST_RUN) begin
                  bus.miim_wctrl <= 1'b0;
                  bus.miim_rstat <= 1'b0;
               end
            end
            ST_GAP: begin
               if (!gap_last)
                  gap_q <= gap_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_miim_rr_scheduler.sv
// Directed self-checking bench for miim_rr_scheduler (GAP_CYC=3, TIMEOUT_CYC=64).
// The eth_miim side is driven step by step with hand-timed strobes.
module tb_miim_rr_scheduler;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   miim_rr_scheduler_if #(.N_REQ(3)) bus ();

   miim_rr_scheduler #(
      .N_REQ       (3),
      .GAP_CYC     (3),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int i, input logic [31:0] c);
      bus.req_cmd[32*i +: 32] = c;
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.grant == '0 && n < 40);
   endtask

   // Engine accepts a write in ISSUE, then finishes one cycle into RUN
   task automatic serve_write();
      bus.miim_wstart = 1'b1;
      bus.miim_busy   = 1'b1;
      step();
      bus.miim_wstart = 1'b0;
      bus.miim_busy   = 1'b0;
      step();
   endtask

   initial begin
      int n;
      int k;
      reset           = 1'b1;
      bus.req_valid   = '0;
      bus.req_cmd     = '0;
      bus.miim_busy   = 1'b0;
      bus.miim_wstart = 1'b0;
      bus.miim_rstart = 1'b0;
      bus.miim_rupd   = 1'b0;
      bus.miim_prsd   = '0;
      step();
      step();
      check("rst_grant", 32'(bus.grant), 32'h0);
      check("rst_done",  32'(bus.rsp_done), 32'h0);
      check("rst_wctrl", 32'(bus.miim_wctrl), 32'h0);
      check("rst_rstat", 32'(bus.miim_rstat), 32'h0);
      check("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
      reset = 1'b0;

      // Single write from requester 0
      set_cmd(0, 32'h8420_1140);
      bus.req_valid = 3'b001;
      step();
      check("wr_grant", 32'(bus.grant), 32'h1);
      check("wr_wctrl", 32'(bus.miim_wctrl), 32'h1);
      check("wr_rstat", 32'(bus.miim_rstat), 32'h0);
      check("wr_fiad",  32'(bus.miim_fiad), 32'h1);
      check("wr_rgad",  32'(bus.miim_rgad), 32'h1);
      check("wr_ctrl",  32'(bus.miim_ctrl), 32'h1140);
      set_cmd(0, 32'h0000_0000);
      step();
      check("wr_wctrl_hold", 32'(bus.miim_wctrl), 32'h1);
      check("wr_ctrl_latched", 32'(bus.miim_ctrl), 32'h1140);
      bus.miim_wstart = 1'b1;
      bus.miim_busy   = 1'b1;
      step();
      check("wr_wctrl_off", 32'(bus.miim_wctrl), 32'h0);
      bus.miim_wstart = 1'b0;
      bus.req_valid   = 3'b000;
      step();
      check("wr_busy_nodone", 32'(bus.rsp_done), 32'h0);
      bus.miim_busy = 1'b0;
      step();
      check("wr_done",  32'(bus.rsp_done), 32'h1);
      check("wr_err",   32'(bus.rsp_err), 32'h0);
      check("wr_grant_clr", 32'(bus.grant), 32'h0);
      step();
      check("wr_done_pulse", 32'(bus.rsp_done), 32'h0);

      // Single read from requester 1; busy low before rupd is not completion
      set_cmd(1, 32'h0440_0000);
      bus.req_valid = 3'b010;
      wait_grant(n);
      check("rd_gap_wait", 32'(n), 32'd3);
      check("rd_grant", 32'(bus.grant), 32'h2);
      check("rd_rstat", 32'(bus.miim_rstat), 32'h1);
      check("rd_wctrl", 32'(bus.miim_wctrl), 32'h0);
      check("rd_fiad",  32'(bus.miim_fiad), 32'h1);
      check("rd_rgad",  32'(bus.miim_rgad), 32'h2);
      bus.miim_rstart = 1'b1;
      bus.miim_busy   = 1'b1;
      step();
      check("rd_rstat_off", 32'(bus.miim_rstat), 32'h0);
      bus.miim_rstart = 1'b0;
      bus.miim_busy   = 1'b0;
      step();
      check("rd_early_idle", 32'(bus.rsp_done), 32'h0);
      bus.miim_busy = 1'b1;
      bus.miim_rupd = 1'b1;
      bus.miim_prsd = 16'h796D;
      step();
      check("rd_busy_nodone", 32'(bus.rsp_done), 32'h0);
      bus.miim_rupd = 1'b0;
      bus.miim_prsd = 16'hFFFF;
      bus.miim_busy = 1'b0;
      step();
      check("rd_done",  32'(bus.rsp_done), 32'h2);
      check("rd_err",   32'(bus.rsp_err), 32'h0);
      check("rd_rdata", 32'(bus.rsp_rdata), 32'h796D);
      bus.req_valid = 3'b000;

      // Timeout: requester 2 read never started, requester 0 waiting
      set_cmd(2, 32'h0860_0000);
      set_cmd(0, 32'h8000_ABCD);
      bus.req_valid = 3'b101;
      wait_grant(n);
      check("to_gap_wait", 32'(n), 32'd4);
      check("to_grant", 32'(bus.grant), 32'h4);
      check("to_rstat", 32'(bus.miim_rstat), 32'h1);
      k = 0;
      do begin
         step();
         k++;
      end while (bus.rsp_done == '0 && k < 100);
      check("to_cycles", 32'(k), 32'd64);
      check("to_done",   32'(bus.rsp_done), 32'h4);
      check("to_err",    32'(bus.rsp_err), 32'h1);
      check("to_rstat_off", 32'(bus.miim_rstat), 32'h0);
      check("to_rdata_kept", 32'(bus.rsp_rdata), 32'h796D);
      bus.req_valid = 3'b001;
      wait_grant(n);
      check("to_next_wait", 32'(n), 32'd4);
      check("to_next_grant", 32'(bus.grant), 32'h1);
      check("to_next_ctrl", 32'(bus.miim_ctrl), 32'hABCD);
      serve_write();
      check("to_next_done", 32'(bus.rsp_done), 32'h1);
      check("to_next_err",  32'(bus.rsp_err), 32'h0);
      bus.req_valid = 3'b000;

      // Reset in the middle of RUN abandons the transaction
      set_cmd(1, 32'h8C00_0001);
      bus.req_valid = 3'b010;
      wait_grant(n);
      check("rr_grant", 32'(bus.grant), 32'h2);
      bus.miim_wstart = 1'b1;
      bus.miim_busy   = 1'b1;
      step();
      bus.miim_wstart = 1'b0;
      step();
      reset = 1'b1;
      step();
      check("rr_grant_clr", 32'(bus.grant), 32'h0);
      check("rr_wctrl", 32'(bus.miim_wctrl), 32'h0);
      check("rr_rstat", 32'(bus.miim_rstat), 32'h0);
      check("rr_done",  32'(bus.rsp_done), 32'h0);
      reset         = 1'b0;
      bus.miim_busy = 1'b0;
      bus.req_valid = 3'b000;
      step();
      check("rr_done_after", 32'(bus.rsp_done), 32'h0);

      // Contention from pointer 0; requester 0 keeps asking
      set_cmd(0, 32'h8000_0000);
      set_cmd(1, 32'h8000_0001);
      set_cmd(2, 32'h8000_0002);
      bus.req_valid = 3'b111;
      step();
      check("ct_grant0", 32'(bus.grant), 32'h1);
      serve_write();
      check("ct_done0", 32'(bus.rsp_done), 32'h1);
      wait_grant(n);
      check("ct_wait1",  32'(n), 32'd4);
      check("ct_grant1", 32'(bus.grant), 32'h2);
      check("ct_ctrl1",  32'(bus.miim_ctrl), 32'h1);
      serve_write();
      check("ct_done1", 32'(bus.rsp_done), 32'h2);
      bus.req_valid = 3'b101;
      wait_grant(n);
      check("ct_wait2",  32'(n), 32'd4);
      check("ct_grant2", 32'(bus.grant), 32'h4);
      serve_write();
      check("ct_done2", 32'(bus.rsp_done), 32'h4);
      bus.req_valid = 3'b001;
      wait_grant(n);
      check("ct_wait0",  32'(n), 32'd4);
      check("ct_grant0b", 32'(bus.grant), 32'h1);
      serve_write();
      check("ct_done0b", 32'(bus.rsp_done), 32'h1);
      bus.req_valid = 3'b000;

      // Engine busy while a request is pending
      bus.miim_busy = 1'b1;
      set_cmd(1, 32'h8000_0001);
      bus.req_valid = 3'b010;
      repeat (6) step();
      check("bz_no_grant", 32'(bus.grant), 32'h0);
      bus.miim_busy = 1'b0;
      step();
      check("bz_grant", 32'(bus.grant), 32'h2);
      serve_write();
      check("bz_done", 32'(bus.rsp_done), 32'h2);
      bus.req_valid = 3'b000;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
